led_pixel_receiver: RTL and testbench

LED_PIXEL_RECEIVER -- requirements
Module: led_pixel_receiver

---
 rtl/led_pkg.sv | 32 +++
 rtl/led_pulse_timer.sv | 101 ++++++++++
 rtl/led_pixel_receiver.sv | 205 ++++++++++++++++++++
 tb/tb_led_pixel_receiver.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared WS2812B definitions: receiver FSM states, nominal line timing
// (in 100 MHz cycles), the GRB pixel layout and a small majority helper.
// Used by both the pixel receiver and the strand transmitter.
package led_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIGH  = 2'd1,
    LOW   = 2'd2,
    ERROR = 2'd3
  } rx_state_t;

  localparam int T0H     = 40;
  localparam int T0L     = 85;
  localparam int T1H     = 80;
  localparam int T1L     = 45;
  localparam int T_RESET = 5000;

  localparam int PIXEL_BITS = 24;

  // Wire order on the strand: green first, blue last, each MSB first.
  typedef struct packed {
    logic [7:0] green;
    logic [7:0] red;
    logic [7:0] blue;
  } grb_pixel_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/led_pulse_timer.sv
// Front end of the WS2812B receiver: 2-flop synchronizer, optional 3-sample
// majority filter (enabled by defining LED_RX_GLITCH_FILTER_EN, adds two
// cycles of latency), edge detection and saturating high/low run counters.
// high_cnt holds the width of the current/last high pulse (saturates at
// T_MAX_HIGH+1); low_cnt holds the length of the current low run
// (saturates at T_RESET) and is zero while the line is high.
module led_pulse_timer #(
  parameter int T_MAX_HIGH = 120,
  parameter int T_RESET    = led_pkg::T_RESET,
  parameter int HIGH_W     = $clog2(T_MAX_HIGH + 2),
  parameter int LOW_W      = $clog2(T_RESET + 1)
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              strand_in,
  output logic              rise,
  output logic              fall,
  output logic [HIGH_W-1:0] high_cnt,
  output logic [LOW_W-1:0]  low_cnt
);

  localparam logic [HIGH_W-1:0] HIGH_SAT = HIGH_W'(T_MAX_HIGH + 1);
  localparam logic [LOW_W-1:0]  LOW_SAT  = LOW_W'(T_RESET);

  logic sync_meta;
  logic sync_q;
  logic line;
  logic line_d;

  // Two-flop synchronizer for the asynchronous strand pin.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      sync_meta <= strand_in;
      sync_q    <= sync_meta;
    end
  end

`ifdef LED_RX_GLITCH_FILTER_EN
  logic [1:0] hist;
  logic       filt;

  // Registered majority over three consecutive samples drops 1-cycle spikes.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      hist <= 2'b00;
      filt <= 1'b0;
    end else begin
      hist <= {hist[0], sync_q};
      filt <= led_pkg::majority3(sync_q, hist[0], hist[1]);
    end
  end

  assign line = filt;
`else
  assign line = sync_q;
`endif

  // Delayed copy of the decoded line for edge detection.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      line_d <= 1'b0;
    end else begin
      line_d <= line;
    end
  end

  assign rise = line & ~line_d;
  assign fall = ~line & line_d;

  // High-width counter: restarts on a rising edge, holds after the fall.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      high_cnt <= '0;
    end else if (rise) begin
      high_cnt <= HIGH_W'(1);
    end else if (line && (high_cnt < HIGH_SAT)) begin
      high_cnt <= high_cnt + HIGH_W'(1);
    end else begin
      high_cnt <= high_cnt;
    end
  end

  // Low-run counter: zero while high, restarts on a fall, saturates at T_RESET.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      low_cnt <= '0;
    end else if (rise) begin
      low_cnt <= '0;
    end else if (fall) begin
      low_cnt <= LOW_W'(1);
    end else if (!line && (low_cnt < LOW_SAT)) begin
      low_cnt <= low_cnt + LOW_W'(1);
    end else begin
      low_cnt <= low_cnt;
    end
  end

endmodule

// File: rtl/led_pixel_receiver.sv
// WS2812B strand receiver: decodes high-pulse widths into bits, assembles
// 24-bit GRB pixels and reports them with a position index, frame ends,
// illegal pulses and frames longer than NUM_LEDS pixels.
// Optional glitch filter: define LED_RX_GLITCH_FILTER_EN (see led_pulse_timer).
module led_pixel_receiver #(
  parameter int NUM_LEDS      = 20,
  parameter int T_BIT_THRESH  = 60,
  parameter int T_MIN_HIGH    = 15,
  parameter int T_MAX_HIGH    = 120,
  parameter int T_RESET       = led_pkg::T_RESET,
  parameter int COUNTER_WIDTH = $clog2(NUM_LEDS)
) (
  input  logic                   clk_in,
  input  logic                   rst,
  input  logic                   strand_in,
  output logic [7:0]             green_out,
  output logic [7:0]             red_out,
  output logic [7:0]             blue_out,
  output logic                   pixel_valid,
  output logic [COUNTER_WIDTH:0] pixel_index,
  output logic                   frame_done,
  output logic                   bit_error,
  output logic                   overflow
);

  import led_pkg::*;

  localparam int HIGH_W = $clog2(T_MAX_HIGH + 2);
  localparam int LOW_W  = $clog2(T_RESET + 1);
  localparam int IDX_W  = COUNTER_WIDTH + 1;

  localparam logic [HIGH_W-1:0] MIN_W    = HIGH_W'(T_MIN_HIGH);
  localparam logic [HIGH_W-1:0] THRESH_W = HIGH_W'(T_BIT_THRESH);
  localparam logic [HIGH_W-1:0] MAX_W    = HIGH_W'(T_MAX_HIGH);
  localparam logic [LOW_W-1:0]  RESET_W  = LOW_W'(T_RESET);
  localparam logic [IDX_W-1:0]  LED_LIM  = IDX_W'(NUM_LEDS);
  localparam logic [4:0]        LAST_BIT = 5'd23;

  logic              rise;
  logic              fall;
  logic [HIGH_W-1:0] high_cnt;
  logic [LOW_W-1:0]  low_cnt;

  rx_state_t   state;
  rx_state_t   next_state;
  logic [22:0] shift_reg;
  logic [4:0]  bit_cnt;
  grb_pixel_t  pixel_q;
  grb_pixel_t  new_pixel;

  logic take_bit;
  logic bit_val;
  logic err_pulse;
  logic end_frame;
  logic clear_partial;
  logic pixel_done;
  logic pixel_accept;
  logic pixel_drop;

  led_pulse_timer #(
    .T_MAX_HIGH (T_MAX_HIGH),
    .T_RESET    (T_RESET),
    .HIGH_W     (HIGH_W),
    .LOW_W      (LOW_W)
  ) u_timer (
    .clk_in    (clk_in),
    .rst       (rst),
    .strand_in (strand_in),
    .rise      (rise),
    .fall      (fall),
    .high_cnt  (high_cnt),
    .low_cnt   (low_cnt)
  );

  // FSM state register.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state plus per-cycle decode strobes for the datapath.
  always_comb begin
    next_state    = state;
    take_bit      = 1'b0;
    bit_val       = 1'b0;
    err_pulse     = 1'b0;
    end_frame     = 1'b0;
    clear_partial = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          next_state = HIGH;
        end else begin
          next_state = IDLE;
        end
      end
      HIGH: begin
        if (high_cnt > MAX_W) begin
          err_pulse     = 1'b1;
          clear_partial = 1'b1;
          next_state    = ERROR;
        end else if (fall) begin
          next_state = LOW;
          if (high_cnt < MIN_W) begin
            err_pulse = 1'b1;
          end else begin
            take_bit = 1'b1;
            bit_val  = (high_cnt >= THRESH_W);
          end
        end else begin
          next_state = HIGH;
        end
      end
      LOW: begin
        // A line that rises exactly as the reset time completes still ends the frame.
        if (low_cnt == RESET_W) begin
          end_frame  = 1'b1;
          next_state = rise ? HIGH : IDLE;
        end else if (rise) begin
          next_state = HIGH;
        end else begin
          next_state = LOW;
        end
      end
      ERROR: begin
        if (low_cnt == RESET_W) begin
          end_frame  = 1'b1;
          next_state = rise ? HIGH : IDLE;
        end else begin
          next_state = ERROR;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign pixel_done   = take_bit && (bit_cnt == LAST_BIT);
  assign pixel_accept = pixel_done && (pixel_index < LED_LIM);
  assign pixel_drop   = pixel_done && !(pixel_index < LED_LIM);
  assign new_pixel    = grb_pixel_t'({shift_reg, bit_val});

  // Bit assembly: shift MSB-first, discard partial pixels on frame end or error.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (end_frame || clear_partial || pixel_done) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (take_bit) begin
      shift_reg <= {shift_reg[21:0], bit_val};
      bit_cnt   <= bit_cnt + 5'd1;
    end else begin
      shift_reg <= shift_reg;
      bit_cnt   <= bit_cnt;
    end
  end

  // Colour outputs and the single-cycle status pulses.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      pixel_q     <= '0;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      bit_error   <= 1'b0;
    end else begin
      pixel_valid <= pixel_accept;
      frame_done  <= end_frame;
      bit_error   <= err_pulse;
      if (pixel_accept) begin
        pixel_q <= new_pixel;
      end else begin
        pixel_q <= pixel_q;
      end
    end
  end

  // Frame position advances after each reported pixel; overflow is sticky per frame.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      pixel_index <= '0;
      overflow    <= 1'b0;
    end else if (end_frame) begin
      pixel_index <= '0;
      overflow    <= 1'b0;
    end else begin
      overflow <= overflow | pixel_drop;
      if (pixel_valid) begin
        pixel_index <= pixel_index + IDX_W'(1);
      end else begin
        pixel_index <= pixel_index;
      end
    end
  end

  assign green_out = pixel_q.green;
  assign red_out   = pixel_q.red;
  assign blue_out  = pixel_q.blue;

endmodule

// File: tb/tb_led_pixel_receiver.sv
// Self-checking bench for led_pixel_receiver: table-driven pixel frames,
// a scoreboard of expected pixels checked on pixel_valid, and hand-written
// sequences for overflow, illegal pulses, stuck-high and mid-pixel reset.
module tb_led_pixel_receiver;

  localparam int NUM_LEDS   = 20;
  localparam int T_MAX_HIGH = 120;
  localparam int T_RESET    = 5000;
  localparam int IW         = $clog2(NUM_LEDS) + 1;
`ifdef LED_RX_GLITCH_FILTER_EN
  localparam int LAT        = 5;
  localparam int SPIKE_ERRS = 0;
`else
  localparam int LAT        = 3;
  localparam int SPIKE_ERRS = 1;
`endif

  typedef struct {
    int th0;
    int tl0;
    int th1;
    int tl1;
  } tim_t;

  typedef struct {
    logic [23:0] pix;
    tim_t        t;
    int          exp_idx;
  } vec_t;

  typedef struct {
    logic [7:0]    g;
    logic [7:0]    r;
    logic [7:0]    b;
    logic [IW-1:0] idx;
  } exp_t;

  logic          clk_in = 1'b0;
  logic          rst = 1'b1;
  logic          strand_in = 1'b0;
  logic [7:0]    green_out;
  logic [7:0]    red_out;
  logic [7:0]    blue_out;
  logic          pixel_valid;
  logic [IW-1:0] pixel_index;
  logic          frame_done;
  logic          bit_error;
  logic          overflow;

  led_pixel_receiver #(
    .NUM_LEDS     (NUM_LEDS),
    .T_BIT_THRESH (60),
    .T_MIN_HIGH   (15),
    .T_MAX_HIGH   (T_MAX_HIGH),
    .T_RESET      (T_RESET)
  ) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .strand_in   (strand_in),
    .green_out   (green_out),
    .red_out     (red_out),
    .blue_out    (blue_out),
    .pixel_valid (pixel_valid),
    .pixel_index (pixel_index),
    .frame_done  (frame_done),
    .bit_error   (bit_error),
    .overflow    (overflow)
  );

  always #5 clk_in = ~clk_in;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   n_valid = 0;
  int   n_frame = 0;
  int   n_err = 0;
  int   last_valid_cyc = 0;
  int   last_err_cyc = 0;
  int   last_fall_cyc = 0;
  int   model_idx = 0;
  exp_t sb[$];
  exp_t e_mon;
  vec_t vecs[5];

  tim_t NOM  = '{40, 85, 80, 45};
  tim_t FAST = '{16, 16, 64, 16};

  // Free-running cycle count used to measure latencies.
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h, required %0h", name, act, req);
    end
  endtask

  // Scoreboard consumer and pulse counters, sampled away from the active edge.
  always @(negedge clk_in) begin
    if (!rst) begin
      if (pixel_valid) begin
        n_valid++;
        last_valid_cyc = cyc;
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pixel: actual %h%h%h idx %0d, required no pixel",
                   green_out, red_out, blue_out, pixel_index);
        end else begin
          e_mon = sb.pop_front();
          check("green_out", 32'(green_out), 32'(e_mon.g));
          check("red_out", 32'(red_out), 32'(e_mon.r));
          check("blue_out", 32'(blue_out), 32'(e_mon.b));
          check("pixel_index", 32'(pixel_index), 32'(e_mon.idx));
        end
      end
      if (frame_done) n_frame++;
      if (bit_error) begin
        n_err++;
        last_err_cyc = cyc;
      end
    end
  end

  task automatic push_exp(input logic [23:0] v, input int idx);
    exp_t e;
    e.g   = v[23:16];
    e.r   = v[15:8];
    e.b   = v[7:0];
    e.idx = IW'(idx);
    sb.push_back(e);
  endtask

  task automatic expect_pixel(input logic [23:0] v);
    if (model_idx < NUM_LEDS) begin
      push_exp(v, model_idx);
      model_idx++;
    end
  endtask

  task automatic send_bit(input logic b, input tim_t t);
    strand_in = 1'b1;
    repeat (b ? t.th1 : t.th0) @(negedge clk_in);
    strand_in = 1'b0;
    last_fall_cyc = cyc;
    repeat (b ? t.tl1 : t.tl0) @(negedge clk_in);
  endtask

  task automatic send_bits(input logic [23:0] v, input int msb, input int lsb, input tim_t t);
    for (int i = msb; i >= lsb; i--) send_bit(v[i], t);
  endtask

  task automatic pulse(input int hi, input int lo);
    strand_in = 1'b1;
    repeat (hi) @(negedge clk_in);
    strand_in = 1'b0;
    repeat (lo) @(negedge clk_in);
  endtask

  task automatic end_frame(input string name);
    int f0;
    f0 = n_frame;
    strand_in = 1'b0;
    repeat (T_RESET + 10) @(negedge clk_in);
    check(name, 32'(n_frame - f0), 32'd1);
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("index_cleared", 32'(pixel_index), 32'd0);
    model_idx = 0;
  endtask

  task automatic check_reset_outputs();
    check("rst_green", 32'(green_out), 32'd0);
    check("rst_red", 32'(red_out), 32'd0);
    check("rst_blue", 32'(blue_out), 32'd0);
    check("rst_index", 32'(pixel_index), 32'd0);
    check("rst_valid", 32'(pixel_valid), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_bit_error", 32'(bit_error), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
  endtask

  initial begin
    int v0;
    int e0;
    int r0;
    logic [23:0] pix;

    vecs[0] = '{24'h123456, '{40, 85, 80, 45}, 0};
    vecs[1] = '{24'h00FF00, '{15, 60, 60, 60}, 1};
    vecs[2] = '{24'h800001, '{59, 30, 120, 30}, 2};
    vecs[3] = '{24'hFFFFFF, '{16, 16, 64, 16}, 3};
    vecs[4] = '{24'h0F0F0F, '{16, 16, 64, 16}, 4};

    // Reset state.
    repeat (4) @(negedge clk_in);
    check_reset_outputs();
    rst = 1'b0;
    repeat (4) @(negedge clk_in);

    // Nominal single pixel A5/3C/FF with latency and index advance.
    expect_pixel(24'hA53CFF);
    send_bits(24'hA53CFF, 23, 0, NOM);
    check("valid_latency", 32'(last_valid_cyc - last_fall_cyc), 32'(LAT));
    check("index_after_pixel", 32'(pixel_index), 32'd1);
    end_frame("frame_done_nominal");

    // Table-driven frame covering pulse-width boundaries, then a partial pixel.
    e0 = n_err;
    for (int i = 0; i < 5; i++) begin
      push_exp(vecs[i].pix, vecs[i].exp_idx);
      send_bits(vecs[i].pix, 23, 0, vecs[i].t);
    end
    check("boundary_no_error", 32'(n_err - e0), 32'd0);
    v0 = n_valid;
    send_bits(24'hFFF000, 23, 12, NOM);
    end_frame("frame_done_partial");
    check("partial_dropped", 32'(n_valid - v0), 32'd0);

    // Overflow: 21 pixels into a 20-pixel receiver.
    v0 = n_valid;
    for (int i = 0; i < 21; i++) begin
      pix = {8'(i), 8'hC3 ^ 8'(i), ~8'(i)};
      expect_pixel(pix);
      send_bits(pix, 23, 0, FAST);
      if (i == 19) check("overflow_before", 32'(overflow), 32'd0);
    end
    check("overflow_set", 32'(overflow), 32'd1);
    check("overflow_valid_count", 32'(n_valid - v0), 32'd20);
    check("overflow_index_hold", 32'(pixel_index), 32'd20);
    end_frame("frame_done_overflow");
    check("overflow_cleared", 32'(overflow), 32'd0);

    // Short illegal pulse and single-cycle spike inside pixels.
    e0 = n_err;
    expect_pixel(24'h5AC396);
    send_bits(24'h5AC396, 23, 12, FAST);
    pulse(8, 16);
    send_bits(24'h5AC396, 11, 0, FAST);
    check("short_pulse_error", 32'(n_err - e0), 32'd1);
    expect_pixel(24'h3C5AA5);
    send_bits(24'h3C5AA5, 23, 8, FAST);
    pulse(1, 16);
    send_bits(24'h3C5AA5, 7, 0, FAST);
    check("spike_error", 32'(n_err - e0), 32'(1 + SPIKE_ERRS));
    check("spike_latency", 32'(last_valid_cyc - last_fall_cyc), 32'(LAT));
    end_frame("frame_done_glitch");

    // Line stuck high for 200 cycles.
    e0 = n_err;
    v0 = n_valid;
    r0 = cyc;
    pulse(200, 20);
    check("stuck_high_error", 32'(n_err - e0), 32'd1);
    check("stuck_high_err_cycle", 32'(last_err_cyc - r0), 32'(LAT + T_MAX_HIGH + 1));
    end_frame("frame_done_error");
    check("stuck_high_no_pixel", 32'(n_valid - v0), 32'd0);
    expect_pixel(24'h0F1E2D);
    send_bits(24'h0F1E2D, 23, 0, FAST);
    check("recovery_pixel", 32'(n_valid - v0), 32'd1);

    // Reset in the middle of a pixel, then a fresh black pixel.
    send_bits(24'hFFFFFF, 23, 12, FAST);
    rst = 1'b1;
    repeat (3) @(negedge clk_in);
    check_reset_outputs();
    rst = 1'b0;
    model_idx = 0;
    repeat (3) @(negedge clk_in);
    v0 = n_valid;
    expect_pixel(24'h000000);
    send_bits(24'h000000, 23, 0, FAST);
    check("post_reset_pixel", 32'(n_valid - v0), 32'd1);
    end_frame("frame_done_post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
